// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction-fetch front end and its decode users:
//   - default data/address widths, reset vector and PC increment
//   - fetch FSM state encoding (2-bit: IDLE=0, REQ=1, HOLD=2)
//   - instruction field bit positions plus small field-extraction helpers
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  localparam int          DATA_WIDTH_DEF = 32;
  localparam int          ADDR_WIDTH_DEF = 26;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_1000;
  localparam int          PC_STEP_DEF    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  // Instruction field positions (MSB/LSB) for decode users.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_MSB  = 25;
  localparam int JADDR_LSB  = 0;

  function automatic logic [5:0] instr_opcode(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [5:0] instr_funct(input logic [31:0] instr);
    return instr[FUNCT_MSB:FUNCT_LSB];
  endfunction

  function automatic logic [15:0] instr_imm(input logic [31:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_reg_n.sv
// -----------------------------------------------------------------------------
// reg_n
// Parametrised-width register with load enable and asynchronous active-low
// reset to RESET_VAL.
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset
//   load  in   capture d on the next rising edge
//   d     in   WIDTH-bit data in
//   q     out  WIDTH-bit registered value
// -----------------------------------------------------------------------------
module reg_n
  import instr_fetch_unit_pkg::*;
#(
  parameter int               WIDTH     = DATA_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction-fetch front end: owns PC and IR, issues word reads over a
// req/ack handshake and presents fetched instructions over valid/ready.
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   fetch_en      in   allow new fetches
//   mem_req       out  read request, held until mem_ack
//   mem_addr      out  fetch address, stable while mem_req high
//   mem_ack       in   mem_rdata valid this cycle
//   mem_rdata     in   fetched word
//   redirect      in   one-cycle pulse: load PC from redirect_addr
//   redirect_addr in   branch/jump target
//   ir            out  instruction register
//   ir_pc         out  address ir was fetched from
//   pc_plus       out  ir_pc + PC_STEP
//   ir_valid      out  ir holds an unconsumed instruction
//   ir_ready      in   consumer accepts ir this cycle
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          PC_STEP    = PC_STEP_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic [ADDR_WIDTH-1:0] pc_plus,
  output logic                  ir_valid,
  input  logic                  ir_ready
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_T = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] STEP_T     = ADDR_WIDTH'(PC_STEP);

  fetch_state_t          state, state_next;
  logic                  squash, squash_next;
  logic [ADDR_WIDTH-1:0] pc, pc_d;
  logic                  pc_load;
  logic                  ir_load;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  addr_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      squash <= 1'b0;
    end else begin
      state  <= state_next;
      squash <= squash_next;
    end
  end

  always_comb begin
    state_next  = state;
    squash_next = squash;
    pc_d        = pc;
    pc_load     = 1'b0;
    ir_load     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (fetch_en) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (mem_ack) begin
          // A squashed ack, or one coinciding with a redirect, is dropped:
          // the request simply restarts at the (new) PC.
          if (!squash && !redirect) begin
            ir_load    = 1'b1;
            pc_d       = pc + STEP_T;
            pc_load    = 1'b1;
            state_next = ST_HOLD;
          end
          squash_next = 1'b0;
        end else if (redirect) begin
          // The outstanding read must still complete; mark it for discard.
          squash_next = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect || ir_ready) begin
          state_next = fetch_en ? ST_REQ : ST_IDLE;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        squash_next = 1'b0;
      end
    endcase

    if (redirect) begin
      pc_d    = redirect_addr;
      pc_load = 1'b1;
    end
  end

  // mem_addr is its own register so it can stay frozen on the outstanding
  // request while PC already holds a redirect target; otherwise it follows PC.
  assign addr_load = !((state == ST_REQ) && !mem_ack);
  assign addr_d    = pc_d;

  reg_n #(.WIDTH(ADDR_WIDTH), .RESET_VAL(RESET_PC_T)) u_pc (
    .clk(clk), .rst_n(rst_n), .load(pc_load), .d(pc_d), .q(pc)
  );

  reg_n #(.WIDTH(ADDR_WIDTH), .RESET_VAL(RESET_PC_T)) u_mem_addr (
    .clk(clk), .rst_n(rst_n), .load(addr_load), .d(addr_d), .q(mem_addr)
  );

  reg_n #(.WIDTH(DATA_WIDTH), .RESET_VAL('0)) u_ir (
    .clk(clk), .rst_n(rst_n), .load(ir_load), .d(mem_rdata), .q(ir)
  );

  reg_n #(.WIDTH(ADDR_WIDTH), .RESET_VAL('0)) u_ir_pc (
    .clk(clk), .rst_n(rst_n), .load(ir_load), .d(pc), .q(ir_pc)
  );

  assign mem_req  = (state == ST_REQ);
  assign ir_valid = (state == ST_HOLD);
  assign pc_plus  = ir_pc + STEP_T;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int DW = 32;
  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_en;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic [AW-1:0] pc_plus;
  logic          ir_valid;
  logic          ir_ready;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: transaction-level view of the front end.
  logic [AW-1:0] m_pc;       // next address to fetch
  logic [AW-1:0] m_addr;     // address of the request currently on the bus
  logic          m_req;      // a read is outstanding
  logic          m_squash;   // outstanding read will be discarded
  logic          m_full;     // instruction buffer holds an unconsumed word
  logic [DW-1:0] m_ir;
  logic [AW-1:0] m_ir_pc;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .redirect(redirect), .redirect_addr(redirect_addr),
    .ir(ir), .ir_pc(ir_pc), .pc_plus(pc_plus), .ir_valid(ir_valid),
    .ir_ready(ir_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = 26'h1000;
    m_addr   = 26'h1000;
    m_req    = 1'b0;
    m_squash = 1'b0;
    m_full   = 1'b0;
    m_ir     = '0;
    m_ir_pc  = '0;
  endtask

  task automatic check_all(input string where);
    check_val({where, ":mem_req"},  64'(mem_req),  64'(m_req));
    check_val({where, ":ir_valid"}, 64'(ir_valid), 64'(m_full));
    check_val({where, ":ir"},       64'(ir),       64'(m_ir));
    check_val({where, ":ir_pc"},    64'(ir_pc),    64'(m_ir_pc));
    check_val({where, ":pc_plus"},  64'(pc_plus),  64'(AW'(m_ir_pc + 26'd1)));
    if (m_req) check_val({where, ":mem_addr"}, 64'(mem_addr), 64'(m_addr));
  endtask

  // One clock: drive inputs, advance the model on the edge, check at negedge.
  task automatic cycle(input string where, input logic fe, input logic ack,
                       input logic [DW-1:0] rd, input logic rdy,
                       input logic redir, input logic [AW-1:0] raddr);
    logic start_new;
    fetch_en      = fe;
    mem_ack       = ack;
    mem_rdata     = rd;
    ir_ready      = rdy;
    redirect      = redir;
    redirect_addr = raddr;
    @(posedge clk);
    start_new = 1'b0;
    if (m_req) begin
      if (ack) begin
        if (!m_squash && !redir) begin
          m_ir    = rd;
          m_ir_pc = m_addr;
          m_pc    = m_addr + 26'd1;
          m_req   = 1'b0;
          m_full  = 1'b1;
        end else begin
          m_squash  = 1'b0;
          start_new = 1'b1;
        end
      end else if (redir) begin
        m_squash = 1'b1;
      end
    end else if (m_full) begin
      if (redir || rdy) begin
        m_full    = 1'b0;
        m_req     = fe;
        start_new = fe;
      end
    end else begin
      m_req     = fe;
      start_new = fe;
    end
    if (redir) m_pc = raddr;
    if (start_new) m_addr = m_pc;
    @(negedge clk);
    check_all(where);
  endtask

  task automatic do_reset(input string where);
    rst_n   = 1'b0;
    mem_ack = 1'b1;  // stray ack during reset must be ignored
    #1;
    model_reset();
    check_val({where, ":rst_mem_req"},  64'(mem_req),  64'd0);
    check_val({where, ":rst_ir_valid"}, 64'(ir_valid), 64'd0);
    check_val({where, ":rst_mem_addr"}, 64'(mem_addr), 64'h1000);
    check_val({where, ":rst_ir"},       64'(ir),       64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Ack arriving after reset, before any request, is also ignored.
    cycle({where, ":post_rst_ack"}, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [31:0] r;
    logic [AW-1:0] ra;
    logic fe, ack, rdy, redir;

    rst_n = 1'b0; fetch_en = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    redirect = 1'b0; redirect_addr = '0; ir_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset("init");

    // Fetch with three wait states, then stall, then consume.
    cycle("req0",  1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check_val("req0_addr_1000", 64'(mem_addr), 64'h1000);
    for (int i = 0; i < 3; i++) cycle("wait", 1'b1, 1'b0, $urandom, 1'b0, 1'b0, '0);
    cycle("ack0",  1'b1, 1'b1, 32'h2002_0005, 1'b0, 1'b0, '0);
    check_val("ack0_ir",      64'(ir),      64'h2002_0005);
    check_val("ack0_pc_plus", 64'(pc_plus), 64'h1001);
    for (int i = 0; i < 5; i++) cycle("stall", 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    cycle("consume", 1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    check_val("consume_addr_1001", 64'(mem_addr), 64'h1001);

    // Redirect before ack, then redirect coinciding with ack.
    cycle("redir_req",   1'b1, 1'b0, '0, 1'b0, 1'b1, 26'h2000);
    cycle("squash_ack",  1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0, '0);
    check_val("squash_addr_2000", 64'(mem_addr), 64'h2000);
    cycle("redir_ack",   1'b1, 1'b1, 32'h2222_2222, 1'b0, 1'b1, 26'h2000);
    cycle("ack_2000",    1'b1, 1'b1, 32'h0000_0011, 1'b0, 1'b0, '0);

    // Redirect in HOLD to the top of the address space, then wrap.
    cycle("redir_hold",  1'b1, 1'b0, '0, 1'b0, 1'b1, 26'h3FF_FFFF);
    cycle("ack_top",     1'b1, 1'b1, 32'h0000_0022, 1'b0, 1'b0, '0);
    check_val("wrap_pc_plus", 64'(pc_plus), 64'd0);
    cycle("wrap_req",    1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    check_val("wrap_addr_0", 64'(mem_addr), 64'd0);

    // Randomized traffic against the model, with one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        cycle("pre_rst", 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        do_reset("mid");
        cycle("post_rst", 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        check_val("post_rst_addr", 64'(mem_addr), 64'h1000);
      end
      fe    = ($urandom_range(0, 9) != 0);
      ack   = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 15) == 0);
      r     = $urandom;
      ra    = r[AW-1:0];
      if ($urandom_range(0, 3) == 0) ra = 26'h3FF_FFFF - AW'($urandom_range(0, 2));
      cycle("rand", fe, ack, $urandom, rdy, redir, ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised instruction-fetch front end for the cs147sec05 processor: owns the program counter and instruction register, issues word reads to instruction memory over a req/ack handshake, and hands fetched instructions to the control/decode stage over a valid/ready handshake. Successor to the hard-wired 32-bit PC/IR pair in the data path: generalised in data/address width and reset vector, and adds wait-state tolerance, stall, and branch/jump redirect with in-flight squash.

## Interface
- DATA_WIDTH, 32, instruction/data word width
- ADDR_WIDTH, 26, PC and memory address width; PC wraps modulo 2^ADDR_WIDTH
- RESET_PC, 'h1000, PC value after reset (truncated to ADDR_WIDTH)
- PC_STEP, 1, PC increment per instruction (word addressing)

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset; one clock, asynchronous, active-low
- FETCH_EN  in  1  control allows new fetches
- MEM_REQ  out  1  read request, held until MEM_ACK
- MEM_ADDR  out  ADDR_WIDTH  fetch address, stable while MEM_REQ high
- MEM_ACK  in  1  memory returns MEM_RDATA this cycle
- MEM_RDATA  in  DATA_WIDTH  fetched word
- REDIRECT  in  1  one-cycle pulse: load PC from REDIRECT_ADDR
- REDIRECT_ADDR  in  ADDR_WIDTH  branch/jump target
- IR  out  DATA_WIDTH  instruction register
- IR_PC  out  ADDR_WIDTH  address IR was fetched from
- PC_PLUS  out  ADDR_WIDTH  IR_PC + PC_STEP (for jal / branch base)
- IR_VALID  out  1  IR holds an unconsumed instruction
- IR_READY  in  1  consumer accepts IR this cycle when IR_VALID high

## Operation
- Registers: PC, IR, IR_PC, state, SQUASH flag.
- States: IDLE, REQ, HOLD.
- IDLE: MEM_REQ=0. FETCH_EN=1 -> REQ.
- REQ: MEM_REQ=1, MEM_ADDR=PC. On MEM_ACK with SQUASH=0: IR<=MEM_RDATA, IR_PC<=PC, PC<=PC+PC_STEP, -> HOLD. On MEM_ACK with SQUASH=1: data dropped, SQUASH<=0, stay REQ (re-request new PC).
- HOLD: IR_VALID=1, MEM_REQ=0. On IR_READY: -> REQ if FETCH_EN else IDLE. No IR_READY: hold (stall), IR/IR_PC stable.
- REDIRECT (any state, highest priority): PC<=REDIRECT_ADDR. In REQ without same-cycle MEM_ACK: SQUASH<=1 (outstanding request must still complete; MEM_REQ stays high, MEM_ADDR switches only after that ack). In REQ with same-cycle MEM_ACK: data dropped, IR unchanged, stay REQ with new PC. In HOLD: IR_VALID cleared, -> REQ if FETCH_EN else IDLE. In IDLE: PC loaded only.
- FETCH_EN low never aborts an outstanding request; unit returns to IDLE after HOLD is consumed.
- PC arithmetic: unsigned, ADDR_WIDTH bits, carry discarded; PC_PLUS likewise.

## Timing
- Reset values: PC=RESET_PC, IR=0, IR_PC=0, IR_VALID=0, MEM_REQ=0, MEM_ADDR=RESET_PC, state IDLE, SQUASH=0.
- All outputs registered or decoded from state only (no combinational path from MEM_ACK/IR_READY to outputs).
- FETCH_EN high in IDLE at cycle N -> MEM_REQ high from N+1.
- MEM_ACK at cycle N -> IR_VALID high from N+1; earliest next MEM_REQ at N+2 (IR_READY at N+1).
- Zero-wait-state memory: one instruction per 2 cycles.
- RST assertion mid-REQ: MEM_REQ drops immediately; an ack arriving during/after reset before a new request is ignored.

## Structure
- Shared package/defines file: DATA_WIDTH/ADDR_WIDTH defaults, RESET_PC, state encodings (2-bit: IDLE=0, REQ=1, HOLD=2), instruction field positions (opcode 31:26, rs 25:21, rt 20:16, rd 15:11, shamt 10:6, funct 5:0, imm 15:0, addr 25:0) for decode users.
- One sub-module: reg_n, parametrised-width register with load enable and async active-low reset to a parameter value; instantiated for PC, IR, IR_PC.

## Test plan
- Reset: RST low mid-run -> MEM_REQ=0, IR_VALID=0, PC=MEM_ADDR='h1000 same cycle; release, FETCH_EN=1 -> MEM_REQ at next edge, MEM_ADDR='h1000.
- Wait states: ack 3 cycles after MEM_REQ with RDATA='h2002_0005 -> MEM_ADDR stable throughout, IR='h2002_0005, IR_PC='h1000, PC_PLUS='h1001, IR_VALID next cycle.
- Stall: hold IR_READY low 5 cycles -> IR stable, MEM_REQ=0; assert IR_READY -> MEM_REQ next cycle, MEM_ADDR='h1001.
- Redirect during REQ (before ack), REDIRECT_ADDR='h2000 -> first ack's data dropped, IR_VALID stays 0, re-request at 'h2000; repeat with REDIRECT and MEM_ACK same cycle -> same result.
- Redirect in HOLD -> IR_VALID drops next cycle, next fetch at REDIRECT_ADDR.
- Wrap: REDIRECT_ADDR='h3FF_FFFF, ack -> IR_PC='h3FF_FFFF, PC_PLUS=0, next MEM_ADDR=0.
